hilo_mdu: RTL and testbench

//   Next-generation HI/LO unit: owns the HI/LO register pair and adds multiply, iterative divide
//   and MTHI/MTLO writes. Sits beside the EXE stage. The pipeline issues one op per handshake,
//   and stalls on busy while a divide runs. HI/LO are read directly by the MFHI/MFLO datapath.

---
 rtl/hilo_mdu_pkg.sv | 18 +
 rtl/hilo_mdu_div_core.sv | 65 ++++++
 rtl/hilo_mdu.sv | 145 ++++++++++++++
 tb/tb_hilo_mdu.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared op codes and FSM encodings for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

   localparam logic [3:0] HILO_OP_MULT  = 4'd0;
   localparam logic [3:0] HILO_OP_MULTU = 4'd1;
   localparam logic [3:0] HILO_OP_DIV   = 4'd2;
   localparam logic [3:0] HILO_OP_DIVU  = 4'd3;
   localparam logic [3:0] HILO_OP_MTHI  = 4'd4;
   localparam logic [3:0] HILO_OP_MTLO  = 4'd5;
   localparam logic [3:0] HILO_OP_MADD  = 4'd6;
   localparam logic [3:0] HILO_OP_MADDU = 4'd7;
   localparam logic [3:0] HILO_OP_MSUB  = 4'd8;
   localparam logic [3:0] HILO_OP_MSUBU = 4'd9;

   localparam logic [0:0] HILO_IDLE = 1'b0;
   localparam logic [0:0] HILO_DIV  = 1'b1;

endpackage

// File: rtl/hilo_mdu_div_core.sv
// Restoring divider datapath: one quotient bit per clock on unsigned magnitudes.
module hilo_div_core #(
   parameter int DATA_W = 32
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0]  cnt;
   logic              active;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] dvs;
   logic [DATA_W:0]   trial;
   logic [DATA_W:0]   diff;

   // diff[DATA_W] set means the trial subtraction borrowed: keep the old partial remainder
   always_comb begin
      trial = {rem, quo[DATA_W-1]};
      diff  = trial - {1'b0, dvs};
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         cnt    <= '0;
         active <= 1'b0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
      end else if (abort) begin
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         cnt    <= CNT_INIT;
         active <= 1'b1;
         quo    <= dividend;
         rem    <= '0;
         dvs    <= divisor;
      end else if (active) begin
         if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
            quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
            rem <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
         end else begin
            active <= 1'b0;
         end
      end
   end

   assign done      = active && (cnt == '0);
   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO unit: multiply, iterative divide, MTHI/MTLO; HILO_MADD_EN adds MADD/MSUB accumulate.
//   state     | meaning
//   HILO_IDLE | ready; single-cycle ops commit at the accept edge
//   HILO_DIV  | divide iterating in hilo_div_core; op_ready low
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst_n,
   input  logic              op_valid,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic              op_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [0:0]          state;
   logic                accept;
   logic                div_start;
   logic                signed_mul;
   logic                signed_div;
   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] b_ext;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   a_abs;
   logic [DATA_W-1:0]   b_abs;
   logic                neg_q;
   logic                neg_r;
   logic                div_zero;
   logic [DATA_W-1:0]   a_raw;
   logic                core_done;
   logic [DATA_W-1:0]   core_quo;
   logic [DATA_W-1:0]   core_rem;
   logic [DATA_W-1:0]   q_fix;
   logic [DATA_W-1:0]   r_fix;

   assign busy     = (state == HILO_DIV);
   assign op_ready = ~busy;
   assign accept   = op_valid & ~busy & ~flush;

   assign signed_mul = (op == HILO_OP_MULT) || (op == HILO_OP_MADD) || (op == HILO_OP_MSUB);
   assign signed_div = (op == HILO_OP_DIV);
   assign div_start  = accept && ((op == HILO_OP_DIV) || (op == HILO_OP_DIVU));

   // Sign-extending to 2*DATA_W lets one unsigned multiplier serve both signednesses
   assign a_ext = {{DATA_W{signed_mul & src_a[DATA_W-1]}}, src_a};
   assign b_ext = {{DATA_W{signed_mul & src_b[DATA_W-1]}}, src_b};
   assign prod  = a_ext * b_ext;

   assign a_abs = (signed_div && src_a[DATA_W-1]) ? -src_a : src_a;
   assign b_abs = (signed_div && src_b[DATA_W-1]) ? -src_b : src_b;
   assign q_fix = neg_q ? -core_quo : core_quo;
   assign r_fix = neg_r ? -core_rem : core_rem;

   hilo_div_core #(
      .DATA_W (DATA_W)
   ) u_div_core (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .start       (div_start),
      .abort       (busy & flush),
      .dividend    (a_abs),
      .divisor     (b_abs),
      .done        (core_done),
      .quotient    (core_quo),
      .remainder   (core_rem)
   );

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state    <= HILO_IDLE;
         hi_o     <= '0;
         lo_o     <= '0;
         done     <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         a_raw    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            HILO_IDLE: begin
               if (accept) begin
                  case (op)
                     HILO_OP_MULT, HILO_OP_MULTU: begin
                        {hi_o, lo_o} <= prod;
                        done         <= 1'b1;
                     end
                     HILO_OP_MTHI: begin
                        hi_o <= src_a;
                        done <= 1'b1;
                     end
                     HILO_OP_MTLO: begin
                        lo_o <= src_a;
                        done <= 1'b1;
                     end
                     HILO_OP_DIV, HILO_OP_DIVU: begin
                        state    <= HILO_DIV;
                        neg_q    <= signed_div & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        neg_r    <= signed_div & src_a[DATA_W-1];
                        div_zero <= (src_b == '0);
                        a_raw    <= src_a;
                     end
`ifdef HILO_MADD_EN
                     HILO_OP_MADD, HILO_OP_MADDU: begin
                        {hi_o, lo_o} <= {hi_o, lo_o} + prod;
                        done         <= 1'b1;
                     end
                     HILO_OP_MSUB, HILO_OP_MSUBU: begin
                        {hi_o, lo_o} <= {hi_o, lo_o} - prod;
                        done         <= 1'b1;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            HILO_DIV: begin
               if (flush) begin
                  state <= HILO_IDLE;
               end else if (core_done) begin
                  state <= HILO_IDLE;
                  done  <= 1'b1;
                  if (div_zero) begin
                     lo_o <= '1;
                     hi_o <= a_raw;
                  end else begin
                     lo_o <= q_fix;
                     hi_o <= r_fix;
                  end
               end
            end
            default: state <= HILO_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu against an arithmetic reference model (honours HILO_MADD_EN).
module tb_hilo_mdu;
   import hilo_mdu_pkg::*;

   localparam int W = 32;

   logic         cpu_clk_50M = 1'b0;
   logic         cpu_rst_n   = 1'b1;
   logic         op_valid    = 1'b0;
   logic [3:0]   op          = 4'd0;
   logic [W-1:0] src_a       = '0;
   logic [W-1:0] src_b       = '0;
   logic         flush       = 1'b0;
   logic         op_ready;
   logic         busy;
   logic         done;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   always #10 cpu_clk_50M = ~cpu_clk_50M;

   hilo_mdu #(.DATA_W(W)) dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .op_valid    (op_valid),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .flush       (flush),
      .op_ready    (op_ready),
      .busy        (busy),
      .done        (done),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   // Reference: what HI/LO should hold after an op; upd tells whether done should pulse
   task automatic model_apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic upd);
      longint sa, sb;
      logic [2*W-1:0] acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      acc = {exp_hi, exp_lo};
      upd = 1'b1;
      case (o)
         HILO_OP_MULT:  acc = 64'(sa * sb);
         HILO_OP_MULTU: acc = 64'(a) * 64'(b);
         HILO_OP_MTHI:  acc[2*W-1:W] = a;
         HILO_OP_MTLO:  acc[W-1:0] = a;
         HILO_OP_DIV: begin
            if (b == 0)                          acc = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && sb == -1) acc = {32'h0, 32'h8000_0000};
            else                                  acc = {32'(sa % sb), 32'(sa / sb)};
         end
         HILO_OP_DIVU: begin
            if (b == 0) acc = {a, 32'hFFFF_FFFF};
            else        acc = {a % b, a / b};
         end
`ifdef HILO_MADD_EN
         HILO_OP_MADD:  acc = acc + 64'(sa * sb);
         HILO_OP_MADDU: acc = acc + 64'(a) * 64'(b);
         HILO_OP_MSUB:  acc = acc - 64'(sa * sb);
         HILO_OP_MSUBU: acc = acc - 64'(a) * 64'(b);
`endif
         default: upd = 1'b0;
      endcase
      {exp_hi, exp_lo} = acc;
   endtask

   // Presents one op for a single cycle while idle; returns at the negedge after the accept edge
   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge cpu_clk_50M);
      op = o; src_a = a; src_b = b; op_valid = 1'b1;
      @(negedge cpu_clk_50M);
      op_valid = 1'b0;
   endtask

   task automatic run_div(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit offer, output int cycles, output logic done_seen);
      issue(o, a, b);
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         if (offer && cycles == 4) begin
            op = HILO_OP_MTHI; src_a = 32'hDEAD_BEEF; op_valid = 1'b1;
         end
         if (offer && cycles == 9) op_valid = 1'b0;
         @(negedge cpu_clk_50M);
      end
      op_valid  = 1'b0;
      done_seen = done;
   endtask

   task automatic test_reset;
      #1 cpu_rst_n = 1'b0;
      #2;
      n_cmp++; if ({hi_o, lo_o} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {hi_o, lo_o}); end
      n_cmp++; if (busy !== 1'b0 || op_ready !== 1'b1 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_ctrl: busy=%b ready=%b done=%b want 0 1 0", busy, op_ready, done);
      end
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;
   endtask

   task automatic test_mult;
      logic upd;
      logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
      issue(HILO_OP_MULT, -32'sd3, 32'd7);
      model_apply(HILO_OP_MULT, -32'sd3, 32'd7, upd);
      n_cmp++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFEB || done !== 1'b1) begin
         n_err++; $display("FAIL mult_neg: got %h done=%b want ffffffffffffffeb done=1", {hi_o, lo_o}, done);
      end
      @(negedge cpu_clk_50M);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_width: done=%b want 0", done); end
      issue(HILO_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      model_apply(HILO_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, upd);
      n_cmp++; if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) begin
         n_err++; $display("FAIL multu_max: got %h want fffffffe00000001", {hi_o, lo_o});
      end
      for (int i = 0; i < 40; i++) begin
         logic [3:0] o;
         logic [W-1:0] a, b;
         o = ops[$urandom_range(0, 9)];
         a = $urandom; b = $urandom;
         if (i % 3 == 0) a = 32'($urandom_range(0, 20)) - 32'd10;
         issue(o, a, b);
         model_apply(o, a, b, upd);
         n_cmp++; if ({hi_o, lo_o} !== {exp_hi, exp_lo} || done !== upd) begin
            n_err++; $display("FAIL rand_op%0d: op=%0d a=%h b=%h got %h done=%b want %h done=%b",
                              i, o, a, b, {hi_o, lo_o}, done, {exp_hi, exp_lo}, upd);
         end
      end
   endtask

   task automatic test_div;
      int cyc;
      logic dn, upd;
      run_div(HILO_OP_DIV, -32'sd7, 32'd2, 1'b1, cyc, dn);
      model_apply(HILO_OP_DIV, -32'sd7, 32'd2, upd);
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 33", cyc); end
      n_cmp++; if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF || dn !== 1'b1) begin
         n_err++; $display("FAIL div_neg: got hi=%h lo=%h done=%b want ffffffff fffffffd 1", hi_o, lo_o, dn);
      end
      @(negedge cpu_clk_50M);
      n_cmp++; if (done !== 1'b0 || hi_o !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL div_after: done=%b hi=%h want 0 ffffffff", done, hi_o);
      end
      run_div(HILO_OP_DIVU, 32'd100, 32'd7, 1'b0, cyc, dn);
      model_apply(HILO_OP_DIVU, 32'd100, 32'd7, upd);
      n_cmp++; if (lo_o !== 32'd14 || hi_o !== 32'd2 || dn !== 1'b1) begin
         n_err++; $display("FAIL divu_100_7: got hi=%h lo=%h done=%b want 2 e 1", hi_o, lo_o, dn);
      end
      for (int i = 0; i < 12; i++) begin
         logic [3:0] o;
         logic [W-1:0] a, b;
         o = ($urandom_range(0, 1) == 0) ? HILO_OP_DIV : HILO_OP_DIVU;
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 255));
            2: b = 32'd0 - 32'($urandom_range(1, 255));
            default: b = 32'($urandom_range(1, 3)) << $urandom_range(0, 28);
         endcase
         run_div(o, a, b, 1'b0, cyc, dn);
         model_apply(o, a, b, upd);
         n_cmp++; if ({hi_o, lo_o} !== {exp_hi, exp_lo} || dn !== 1'b1 || cyc !== 33) begin
            n_err++; $display("FAIL rand_div%0d: op=%0d a=%h b=%h got %h done=%b cyc=%0d want %h 1 33",
                              i, o, a, b, {hi_o, lo_o}, dn, cyc, {exp_hi, exp_lo});
         end
      end
   endtask

   task automatic test_div_edge;
      int cyc;
      logic dn, upd;
      run_div(HILO_OP_DIV, 32'd5, 32'd0, 1'b0, cyc, dn);
      model_apply(HILO_OP_DIV, 32'd5, 32'd0, upd);
      n_cmp++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'd5 || dn !== 1'b1) begin
         n_err++; $display("FAIL div_by_zero: got hi=%h lo=%h done=%b want 5 ffffffff 1", hi_o, lo_o, dn);
      end
      run_div(HILO_OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, cyc, dn);
      model_apply(HILO_OP_DIV, 32'hFFFF_FFF0, 32'd0, upd);
      n_cmp++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'hFFFF_FFF0) begin
         n_err++; $display("FAIL div_neg_by_zero: got hi=%h lo=%h want fffffff0 ffffffff", hi_o, lo_o);
      end
      run_div(HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, dn);
      model_apply(HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, upd);
      n_cmp++; if (lo_o !== 32'h8000_0000 || hi_o !== 32'h0) begin
         n_err++; $display("FAIL div_min_m1: got hi=%h lo=%h want 0 80000000", hi_o, lo_o);
      end
   endtask

   task automatic test_flush;
      logic upd;
      int pulses;
      logic [W-1:0] a;
      a = $urandom | 32'h1000;
      issue(HILO_OP_DIVU, a, 32'd3);
      repeat (9) @(negedge cpu_clk_50M);
      flush = 1'b1;
      @(negedge cpu_clk_50M);
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || {hi_o, lo_o} !== {exp_hi, exp_lo}) begin
         n_err++; $display("FAIL flush_abort: busy=%b done=%b hilo=%h want 0 0 %h", busy, done, {hi_o, lo_o}, {exp_hi, exp_lo});
      end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge cpu_clk_50M);
         if (done === 1'b1 || {hi_o, lo_o} !== {exp_hi, exp_lo}) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL flush_quiet: got %0d events want 0", pulses); end
      @(negedge cpu_clk_50M);
      op = HILO_OP_MTHI; src_a = ~exp_hi; op_valid = 1'b1; flush = 1'b1;
      @(negedge cpu_clk_50M);
      op_valid = 1'b0; flush = 1'b0;
      n_cmp++; if (hi_o !== exp_hi || done !== 1'b0) begin
         n_err++; $display("FAIL flush_blocks_op: hi=%h done=%b want %h 0", hi_o, done, exp_hi);
      end
      begin
         int cyc;
         logic dn;
         run_div(HILO_OP_DIVU, a, 32'd3, 1'b0, cyc, dn);
         model_apply(HILO_OP_DIVU, a, 32'd3, upd);
         n_cmp++; if ({hi_o, lo_o} !== {exp_hi, exp_lo} || cyc !== 33) begin
            n_err++; $display("FAIL div_after_flush: got %h cyc=%0d want %h 33", {hi_o, lo_o}, cyc, {exp_hi, exp_lo});
         end
      end
   endtask

   task automatic test_back_to_back;
      logic upd;
      @(negedge cpu_clk_50M);
      op = HILO_OP_MTHI; src_a = 32'h1234; src_b = 32'h0; op_valid = 1'b1;
      @(negedge cpu_clk_50M);
      n_cmp++; if (hi_o !== 32'h1234 || done !== 1'b1) begin
         n_err++; $display("FAIL mthi: hi=%h done=%b want 1234 1", hi_o, done);
      end
      op = HILO_OP_MTLO; src_a = 32'h5678;
      @(negedge cpu_clk_50M);
      op_valid = 1'b0;
      model_apply(HILO_OP_MTHI, 32'h1234, 32'h0, upd);
      model_apply(HILO_OP_MTLO, 32'h5678, 32'h0, upd);
      n_cmp++; if (hi_o !== 32'h1234 || lo_o !== 32'h5678 || done !== 1'b1) begin
         n_err++; $display("FAIL mtlo_b2b: hi=%h lo=%h done=%b want 1234 5678 1", hi_o, lo_o, done);
      end
      issue(HILO_OP_MADD, 32'd2, 32'd3);
      model_apply(HILO_OP_MADD, 32'd2, 32'd3, upd);
      n_cmp++; if ({hi_o, lo_o} !== {exp_hi, exp_lo} || done !== upd) begin
         n_err++; $display("FAIL madd: got %h done=%b want %h done=%b", {hi_o, lo_o}, done, {exp_hi, exp_lo}, upd);
      end
      issue(HILO_OP_MSUBU, 32'hFFFF_FFFF, 32'd2);
      model_apply(HILO_OP_MSUBU, 32'hFFFF_FFFF, 32'd2, upd);
      n_cmp++; if ({hi_o, lo_o} !== {exp_hi, exp_lo} || done !== upd) begin
         n_err++; $display("FAIL msubu: got %h done=%b want %h done=%b", {hi_o, lo_o}, done, {exp_hi, exp_lo}, upd);
      end
   endtask

   task automatic test_reset_mid_div;
      logic upd;
      issue(HILO_OP_DIVU, 32'd1000, 32'd9);
      repeat (5) @(negedge cpu_clk_50M);
      #3 cpu_rst_n = 1'b0;
      #2;
      exp_hi = '0; exp_lo = '0;
      n_cmp++; if ({hi_o, lo_o} !== 64'h0 || busy !== 1'b0 || op_ready !== 1'b1 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_div: hilo=%h busy=%b ready=%b done=%b want 0 0 1 0",
                           {hi_o, lo_o}, busy, op_ready, done);
      end
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;
      repeat (40) @(negedge cpu_clk_50M);
      n_cmp++; if ({hi_o, lo_o} !== 64'h0 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_kills_div: hilo=%h done=%b want 0 0", {hi_o, lo_o}, done);
      end
      issue(HILO_OP_MULT, 32'd6, 32'hFFFF_FFFE);
      model_apply(HILO_OP_MULT, 32'd6, 32'hFFFF_FFFE, upd);
      n_cmp++; if ({hi_o, lo_o} !== {exp_hi, exp_lo}) begin
         n_err++; $display("FAIL mult_after_reset: got %h want %h", {hi_o, lo_o}, {exp_hi, exp_lo});
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_edge();
      test_flush();
      test_back_to_back();
      test_reset_mid_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
